// File: rtl/mem_stage_if.sv
// Execute-to-memory request and write-back bundle for mem_stage.
// The master drives the instruction side; the slave drives the write-back side.
interface mem_stage_if;
    logic        In_valid;
    logic [31:0] Ins;
    logic [31:0] Result;
    logic [31:0] Rdata2;
    logic        Out_valid;
    logic [31:0] Wdata;
    logic [4:0]  Wreg;
    logic        Wen;
    logic        Misalign;

    modport master (
        output In_valid, Ins, Result, Rdata2,
        input  Out_valid, Wdata, Wreg, Wen, Misalign
    );

    modport slave (
        input  In_valid, Ins, Result, Rdata2,
        output Out_valid, Wdata, Wreg, Wen, Misalign
    );
endinterface

// File: rtl/mem_stage.sv
// Memory pipeline stage: word load/store on a local RAM, registered write-back.
// Define MEM_STAGE_BYTE_EN to add LB/LBU/SB byte-lane accesses.
module mem_stage #(
    parameter int ADDR_W = 8
) (
    input logic       CLK,
    input logic       RST,
    mem_stage_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [5:0] OP_R  = 6'b000000;
    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011;
`ifdef MEM_STAGE_BYTE_EN
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_SB  = 6'b101000;
`endif

    logic [31:0] mem [DEPTH];

    logic [5:0]        op;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [ADDR_W-1:0] idx;
    logic              misal;
    logic [31:0]       rword;

    logic is_r;
    logic is_imm;
    logic is_lw;
    logic is_sw;

    logic [31:0] n_wdata;
    logic [4:0]  n_wreg;
    logic        n_wen_raw;
    logic        n_wen;
    logic        n_mis;
    logic        st_en;
    logic [31:0] st_data;

    logic unused_bits;

    assign op    = bus.Ins[31:26];
    assign rt    = bus.Ins[20:16];
    assign rd    = bus.Ins[15:11];
    assign idx   = bus.Result[ADDR_W+1:2];
    assign misal = bus.Result[1:0] != 2'b00;
    assign rword = mem[idx];

    assign unused_bits = ^{bus.Ins[25:21],
                           bus.Ins[10:0],
                           bus.Result[31:ADDR_W+2]};

    assign is_r   = op == OP_R;
    assign is_imm = op[5:2] == 4'b0010;
    assign is_lw  = op == OP_LW;
    assign is_sw  = op == OP_SW;

`ifdef MEM_STAGE_BYTE_EN
    logic        is_lb;
    logic        is_lbu;
    logic        is_sb;
    logic [1:0]  lane;
    logic [4:0]  shamt;
    logic [7:0]  rbyte;
    logic [31:0] bmask;
    logic [31:0] bdata;

    assign is_lb  = op == OP_LB;
    assign is_lbu = op == OP_LBU;
    assign is_sb  = op == OP_SB;
    assign lane   = bus.Result[1:0];
    assign shamt  = {lane, 3'b000};
    assign rbyte  = 8'(rword >> shamt);
    assign bmask  = 32'h0000_00FF << shamt;
    assign bdata  = {24'd0, bus.Rdata2[7:0]} << shamt;
`endif

    always_comb begin
        n_wdata   = bus.Result;
        n_wreg    = 5'd0;
        n_wen_raw = 1'b0;
        n_mis     = 1'b0;
        st_en     = 1'b0;
        st_data   = bus.Rdata2;
        unique case (1'b1)
            is_r: begin
                n_wreg    = rd;
                n_wen_raw = 1'b1;
            end
            is_imm: begin
                n_wreg    = rt;
                n_wen_raw = 1'b1;
            end
            is_lw: begin
                n_wreg = rt;
                if (misal) begin
                    n_wdata = 32'd0;
                    n_mis   = 1'b1;
                end else begin
                    n_wdata   = rword;
                    n_wen_raw = 1'b1;
                end
            end
            is_sw: begin
                n_wreg  = rt;
                n_wdata = bus.Rdata2;
                n_mis   = misal;
                st_en   = !misal;
            end
`ifdef MEM_STAGE_BYTE_EN
            is_lb: begin
                n_wreg    = rt;
                n_wdata   = {{24{rbyte[7]}}, rbyte};
                n_wen_raw = 1'b1;
            end
            is_lbu: begin
                n_wreg    = rt;
                n_wdata   = {24'd0, rbyte};
                n_wen_raw = 1'b1;
            end
            // Read-modify-write keeps the other three lanes intact.
            is_sb: begin
                n_wreg  = rt;
                n_wdata = bus.Rdata2;
                st_en   = 1'b1;
                st_data = (rword & ~bmask) | bdata;
            end
`endif
            default: begin
            end
        endcase
    end

    assign n_wen = n_wen_raw && (n_wreg != 5'd0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            bus.Out_valid <= 1'b0;
            bus.Wdata     <= 32'd0;
            bus.Wreg      <= 5'd0;
            bus.Wen       <= 1'b0;
            bus.Misalign  <= 1'b0;
        end else if (!bus.In_valid) begin
            bus.Out_valid <= 1'b0;
            bus.Wen       <= 1'b0;
            bus.Misalign  <= 1'b0;
        end else begin
            bus.Out_valid <= 1'b1;
            bus.Wdata     <= n_wdata;
            bus.Wreg      <= n_wreg;
            bus.Wen       <= n_wen;
            bus.Misalign  <= n_mis;
        end
    end

    // Contents survive reset; only the write itself is gated.
    always_ff @(posedge CLK) begin
        if (!RST && bus.In_valid && st_en) begin
            mem[idx] <= st_data;
        end
    end

endmodule
